// File: rtl/ram_burst_master_if.sv
// Command, write-stream, read-stream and RAM-side signals of ram_burst_master.
// The master modport is the burst master's view; slave is the surrounding logic's view.
interface ram_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;
  logic                  ram_en;
  logic                  ram_wr_rdn;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_wr;
  logic [DATA_WIDTH-1:0] ram_data_rd;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_data_rd,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           ram_en, ram_wr_rdn, ram_addr, ram_data_wr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_data_rd,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           ram_en, ram_wr_rdn, ram_addr, ram_data_wr
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port synchronous RAM: one command becomes a run of RAM
// writes fed from a stream, or RAM reads returned through a 2-entry FIFO with backpressure.
module ram_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rstn,
  ram_burst_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];

  logic       pop;
  logic       issue;
  logic       wr_hs;
  logic [2:0] occ_after_pop;

  always_comb begin
    // NOTE: every signal gets its default first, so no path through the case infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    head_d  = head_q;
    tail_d  = tail_q;
    fifo_d  = fifo_q;
    issue   = 1'b0;
    pop     = (count_q != 2'd0) && bus.rd_ready;
    wr_hs   = (state_q == WRITE) && bus.wr_valid;
    // Words held or already on their way back from the RAM, once this cycle's pop is gone.
    occ_after_pop = 3'(count_q) + 3'(inflight_q) - 3'(pop);

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_hs) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (occ_after_pop < 3'd2) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_after_pop == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The RAM presents read data the cycle after the issue; capture it then.
    inflight_d = issue;
    count_d    = occ_after_pop[1:0];
    if (inflight_q) begin
      fifo_d[tail_q] = bus.ram_data_rd;
      tail_d         = ~tail_q;
    end
    if (pop) head_d = ~head_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      // NOTE: the two FIFO words are reset as well so rd_data reads zero straight out of reset.
      fifo_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fifo_q     <= fifo_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.wr_ready    = (state_q == WRITE);
  assign bus.rd_valid    = (count_q != 2'd0);
  assign bus.rd_data     = fifo_q[head_q];
  assign bus.ram_en      = wr_hs || issue;
  assign bus.ram_wr_rdn  = (state_q == WRITE);
  assign bus.ram_addr    = addr_q;
  assign bus.ram_data_wr = bus.wr_data;

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomized scoreboard bench for ram_burst_master: a behavioural RAM plus reference memory
// predict every RAM access, every returned word and every done pulse.
module tb_ram_burst_master;
  localparam int DW     = 32;
  localparam int AW     = 10;
  localparam int DEPTH  = 1 << AW;
  localparam int BUDGET = 6000;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_beat_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ram_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural single-port RAM: unwritten words read back a known address pattern.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  logic [DW-1:0] ram_mem [DEPTH];
  bit            ram_vld [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_wr_rdn) begin
        ram_mem[bus.ram_addr] <= bus.ram_data_wr;
        ram_vld[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_data_rd <= ram_vld[bus.ram_addr] ? ram_mem[bus.ram_addr] : init_word(bus.ram_addr);
      end
    end
  end

  // Reference model state and scoreboard queues
  logic [DW-1:0] ref_mem [DEPTH];
  wr_beat_t      exp_wr_q[$];
  logic [AW-1:0] exp_rd_addr_q[$];
  logic [DW-1:0] exp_rd_data_q[$];
  int            exp_beats_q[$];
  logic [DW-1:0] wr_drv_q[$];

  int rd_mode = 1;  // 0: rd_ready low, 1: high, 2: random
  int wr_mode = 0;  // 0: wr_valid held, 1: toggling, 2: random

  // Monitor-side bookkeeping
  bit            in_burst = 1'b0;
  int            beats = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            rd_issue_cnt = 0;
  int            rd_hs_cnt = 0;
  int            hs_cyc = 0;
  int            first_valid_cyc = -1;
  int            last_rd_cyc = 0;
  int            first_wr_cyc = -1;
  int            last_wr_cyc = 0;
  bit            was_stall = 1'b0;
  logic [DW-1:0] stall_data = '0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write-stream source
  initial begin
    bit hs;
    bit tog;
    hs  = 1'b0;
    tog = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs && wr_drv_q.size() > 0) void'(wr_drv_q.pop_front());
      if (wr_drv_q.size() > 0) begin
        case (wr_mode)
          0:       bus.wr_valid = 1'b1;
          1:       begin bus.wr_valid = tog; tog = ~tog; end
          default: bus.wr_valid = 1'($urandom_range(0, 1));
        endcase
        bus.wr_data = wr_drv_q[0];
      end else begin
        bus.wr_valid = 1'b0;
      end
      @(negedge clk);
      hs = bus.wr_valid && bus.wr_ready;
    end
  end

  // Read-stream sink
  initial begin
    bus.rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rd_mode)
        0:       bus.rd_ready = 1'b0;
        1:       bus.rd_ready = 1'b1;
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares everything the DUT presents against the scoreboard.
  initial begin
    wr_beat_t w;
    bit       popnow;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        check("reset_outputs",
              {bus.rd_valid, bus.ram_en, bus.busy, bus.done, bus.cmd_ready, bus.wr_ready,
               bus.ram_addr, bus.rd_data},
              {6'b000010, 10'd0, 32'd0});
        in_burst     = 1'b0;
        beats        = 0;
        was_stall    = 1'b0;
        rd_issue_cnt = 0;
        rd_hs_cnt    = 0;
      end else begin
        if (bus.done) begin
          done_cnt++;
          check("done_in_burst", in_burst, 1);
          if (exp_beats_q.size() > 0) check("done_beats", beats, exp_beats_q.pop_front());
          else check("done_unexpected", bus.done, 0);
          in_burst = 1'b0;
        end
        check("cmd_ready_busy", {bus.cmd_ready, bus.busy}, {!in_burst, in_burst});
        if (was_stall) check("rd_hold", {bus.rd_valid, bus.rd_data}, {1'b1, stall_data});
        was_stall  = bus.rd_valid && !bus.rd_ready;
        stall_data = bus.rd_data;
        popnow     = bus.rd_valid && bus.rd_ready;

        if (bus.ram_en && bus.ram_wr_rdn) begin
          if (exp_wr_q.size() > 0) begin
            w = exp_wr_q.pop_front();
            check("ram_write", {bus.ram_addr, bus.ram_data_wr, bus.wr_valid, bus.wr_ready},
                  {w.addr, w.data, 2'b11});
          end else check("ram_write_unexpected", bus.ram_en, 0);
          beats++;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
        end
        if (bus.ram_en && !bus.ram_wr_rdn) begin
          if (exp_rd_addr_q.size() > 0) check("ram_read_addr", bus.ram_addr, exp_rd_addr_q.pop_front());
          else check("ram_read_unexpected", bus.ram_en, 0);
          check("rd_outstanding_le2", (rd_issue_cnt + 1 - rd_hs_cnt - int'(popnow)) <= 2, 1);
          rd_issue_cnt++;
        end
        if (bus.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (popnow) begin
          if (exp_rd_data_q.size() > 0) check("rd_data", bus.rd_data, exp_rd_data_q.pop_front());
          else check("rd_unexpected", bus.rd_valid, 0);
          beats++;
          rd_hs_cnt++;
          last_rd_cyc = cyc;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          in_burst = 1'b1;
          beats    = 0;
          hs_cyc   = cyc;
        end
      end
    end
  end

  // Queue the expected effect of a burst, then present the command until it is accepted.
  task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                         input logic [DW-1:0] base, output bit hs_done);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            hs;
    int            t;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + AW'(i);
      if (wr) begin
        d = (base != '0) ? base + DW'(i) : DW'($urandom);
        wr_drv_q.push_back(d);
        exp_wr_q.push_back(wr_beat_t'{addr: a, data: d});
        ref_mem[a] = d;
      end else begin
        exp_rd_addr_q.push_back(a);
        exp_rd_data_q.push_back(ref_mem[a]);
      end
    end
    exp_beats_q.push_back(int'(len) + 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    hs      = 1'b0;
    hs_done = 1'b0;
    t       = 0;
    while (!hs && t < BUDGET) begin
      @(negedge clk);
      hs      = bus.cmd_valid && bus.cmd_ready;
      hs_done = bus.done;
      @(posedge clk);
      #1;
      t++;
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accepted", hs, 1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_beats_q.size() != 0 || in_burst) && t < BUDGET) begin
      tick(1);
      t++;
    end
    check({name, "_completes"}, t < BUDGET, 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit            hsd;
    int            d0;
    int            n0;
    logic [AW-1:0] ra;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(AW'(i));
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(1);

    // Write A0..A3 at 0x010 with wr_valid held high
    wr_mode = 0;
    first_wr_cyc = -1;
    d0 = done_cnt;
    run_cmd(1'b1, 10'h010, 10'd3, 32'hA0, hsd);
    wait_idle("wr_a");
    check("wr_a_back_to_back", last_wr_cyc - first_wr_cyc, 3);
    check("wr_a_done_once", done_cnt - d0, 1);

    // Read back with rd_ready high: latency and throughput
    rd_mode = 1;
    tick(1);
    first_valid_cyc = -1;
    d0 = done_cnt;
    run_cmd(1'b0, 10'h010, 10'd3, '0, hsd);
    wait_idle("rd_a");
    check("rd_a_latency", first_valid_cyc - hs_cyc, 3);
    check("rd_a_throughput", last_rd_cyc - first_valid_cyc, 3);
    check("rd_a_done_once", done_cnt - d0, 1);

    // Read under backpressure: only two reads may be outstanding
    rd_mode = 0;
    tick(1);
    n0 = rd_issue_cnt;
    run_cmd(1'b0, 10'h010, 10'd3, '0, hsd);
    tick(10);
    check("stall_issue_count", rd_issue_cnt - n0, 2);
    check("stall_head", {bus.rd_valid, bus.rd_data}, {1'b1, 32'hA0});
    rd_mode = 1;
    wait_idle("rd_stall");

    // Wrapping write with gappy wr_valid, then read back
    wr_mode = 1;
    run_cmd(1'b1, 10'h3FE, 10'd3, 32'hB0, hsd);
    wait_idle("wr_wrap");
    wr_mode = 0;
    rd_mode = 2;
    run_cmd(1'b0, 10'h3FE, 10'd3, '0, hsd);
    wait_idle("rd_wrap");

    // Command held during a busy burst is accepted in the done cycle
    d0 = done_cnt;
    run_cmd(1'b0, AW'($urandom), 10'd7, '0, hsd);
    run_cmd(1'b1, AW'($urandom), 10'd5, '0, hsd);
    check("cmd_taken_on_done", hsd, 1);
    wait_idle("busy_cmd");
    check("busy_cmd_done_count", done_cnt - d0, 2);

    // Reset in the middle of a stalled read with the FIFO full
    rd_mode = 0;
    tick(1);
    ra = AW'($urandom);
    n0 = rd_issue_cnt;
    run_cmd(1'b0, ra, 10'd7, '0, hsd);
    tick(6);
    check("fifo_full_before_reset", {bus.rd_valid, 32'(rd_issue_cnt - n0)}, {1'b1, 32'd2});
    rstn = 1'b0;
    #1;
    check("async_reset",
          {bus.rd_valid, bus.ram_en, bus.busy, bus.done, bus.cmd_ready, bus.ram_addr},
          {5'b00001, 10'h000});
    exp_wr_q.delete();
    exp_rd_addr_q.delete();
    exp_rd_data_q.delete();
    exp_beats_q.delete();
    wr_drv_q.delete();
    tick(2);
    rstn = 1'b1;
    rd_mode = 1;
    tick(1);
    run_cmd(1'b0, ra, 10'd7, '0, hsd);
    wait_idle("rd_after_reset");

    // Randomized mix, sometimes back to back
    rd_mode = 2;
    for (int i = 0; i < 25; i++) begin
      wr_mode = int'($urandom_range(0, 2));
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom_range(0, 15)), '0, hsd);
      if ($urandom_range(0, 2) != 0) wait_idle("rand");
    end
    wait_idle("rand_tail");

    // Whole-RAM write then whole-RAM read
    wr_mode = 2;
    ra = AW'($urandom);
    run_cmd(1'b1, ra, 10'h3FF, '0, hsd);
    wait_idle("full_wr");
    run_cmd(1'b0, ra + 10'd1, 10'h3FF, '0, hsd);
    wait_idle("full_rd");

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
